// File: rtl/pong_game_controller.sv
// Pong game sequencer: serve hold, play, point freeze and game over, all timed in video frames.
// Optional PONG_PAUSE_EN macro adds a PAUSED state toggled by Pause edges while in PLAY.
module pong_game_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W        = 7
) (
  input  logic       CLK_100MHz,
  input  logic       Reset,
  input  logic       frameTick,
  input  logic       Start,
  input  logic       Pause,
  input  logic       missL,
  input  logic       missR,
  output logic       ballEnable,
  output logic       ballReset,
  output logic       paddleEnable,
  output logic       serveDir,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_SERVE    = 3'b001,
    S_PLAY     = 3'b010,
    S_POINT    = 3'b011,
    S_GAMEOVER = 3'b100,
    S_PAUSED   = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       score_l_nxt, score_r_nxt;
  logic [1:0]       winner_nxt;
  logic             dir_nxt;
  logic             start_prev, pause_prev, start_edge;

  assign start_edge = Start & ~start_prev;
  assign state      = cur;

`ifdef PONG_PAUSE_EN
  logic pause_edge;
  assign pause_edge = Pause & ~pause_prev;
`else
  logic unused_pause;
  assign unused_pause = pause_prev;
`endif

  always_comb begin
    nxt         = cur;
    cnt_nxt     = cnt;
    score_l_nxt = scoreL;
    score_r_nxt = scoreR;
    winner_nxt  = winner;
    dir_nxt     = serveDir;
    case (cur)
      S_IDLE, S_GAMEOVER: begin
        if (start_edge) begin
          nxt         = S_SERVE;
          cnt_nxt     = '0;
          score_l_nxt = 4'd0;
          score_r_nxt = 4'd0;
          winner_nxt  = 2'b00;
          dir_nxt     = 1'b1;
        end
      end
      S_SERVE: begin
        if (frameTick) begin
          if (cnt == SERVE_LAST) begin
            nxt     = S_PLAY;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        // missL takes priority when both borders report in the same cycle
        if (missL) begin
          nxt         = S_POINT;
          cnt_nxt     = '0;
          score_r_nxt = (scoreR < WIN) ? scoreR + 4'd1 : scoreR;
          dir_nxt     = 1'b0;
        end else if (missR) begin
          nxt         = S_POINT;
          cnt_nxt     = '0;
          score_l_nxt = (scoreL < WIN) ? scoreL + 4'd1 : scoreL;
          dir_nxt     = 1'b1;
        end
`ifdef PONG_PAUSE_EN
        else if (pause_edge) begin
          nxt = S_PAUSED;
        end
`endif
      end
      S_POINT: begin
        if (frameTick) begin
          if (cnt == POINT_LAST) begin
            cnt_nxt = '0;
            if (scoreL == WIN) begin
              nxt        = S_GAMEOVER;
              winner_nxt = 2'b01;
            end else if (scoreR == WIN) begin
              nxt        = S_GAMEOVER;
              winner_nxt = 2'b10;
            end else begin
              nxt = S_SERVE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
`ifdef PONG_PAUSE_EN
      S_PAUSED: begin
        if (pause_edge) nxt = S_PLAY;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      cur          <= S_IDLE;
      cnt          <= '0;
      scoreL       <= 4'd0;
      scoreR       <= 4'd0;
      winner       <= 2'b00;
      serveDir     <= 1'b1;
      start_prev   <= 1'b0;
      pause_prev   <= 1'b0;
      ballEnable   <= 1'b0;
      ballReset    <= 1'b1;
      paddleEnable <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      scoreL     <= score_l_nxt;
      scoreR     <= score_r_nxt;
      winner     <= winner_nxt;
      serveDir   <= dir_nxt;
      start_prev <= Start;
      pause_prev <= Pause;
      // control outputs are decoded from the next state so they change with state
      case (nxt)
        S_SERVE:  begin ballEnable <= 1'b0; ballReset <= 1'b1; paddleEnable <= 1'b1; end
        S_PLAY:   begin ballEnable <= 1'b1; ballReset <= 1'b0; paddleEnable <= 1'b1; end
        S_POINT:  begin ballEnable <= 1'b0; ballReset <= 1'b0; paddleEnable <= 1'b1; end
`ifdef PONG_PAUSE_EN
        S_PAUSED: begin ballEnable <= 1'b0; ballReset <= 1'b0; paddleEnable <= 1'b0; end
`endif
        default:  begin ballEnable <= 1'b0; ballReset <= 1'b1; paddleEnable <= 1'b0; end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: randomized frame timing and noise against a game-level model.
module tb_pong_game_controller;

  localparam int WS = 7;
  localparam int SF = 60;
  localparam int PF = 90;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, GAMEOVER = 4, PAUSED = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       ball_en, ball_rst, paddle_en, serve_dir;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // game-level model
  int ms, ml, mr, mdir, mwin;

  pong_game_controller #(
    .WIN_SCORE(WS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .CNT_W(7)
  ) dut (
    .CLK_100MHz(clk), .Reset(rst_n), .frameTick(frame_tick), .Start(start), .Pause(pause),
    .missL(miss_l), .missR(miss_r), .ballEnable(ball_en), .ballReset(ball_rst),
    .paddleEnable(paddle_en), .serveDir(serve_dir), .scoreL(score_l), .scoreR(score_r),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ballEnable, ballReset, paddleEnable} each game phase must present
  function automatic logic [2:0] exp_ctl(input int s);
    case (s)
      SERVE:   return 3'b011;
      PLAY:    return 3'b101;
      POINT:   return 3'b001;
      PAUSED:  return 3'b000;
      default: return 3'b010;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(ms));
    chk({tag, ".ctl"}, 32'({ball_en, ball_rst, paddle_en}), 32'(exp_ctl(ms)));
    chk({tag, ".scoreL"}, 32'(score_l), 32'(ml));
    chk({tag, ".scoreR"}, 32'(score_r), 32'(mr));
    chk({tag, ".dir"}, 32'(serve_dir), 32'(mdir));
    chk({tag, ".winner"}, 32'(winner), 32'(mwin));
  endtask

  task automatic model_reset();
    ms = IDLE; ml = 0; mr = 0; mdir = 1; mwin = 0;
  endtask

  // n frame ticks with random gaps; misses, Start and Pause jitter are irrelevant outside PLAY
  task automatic ticks(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          miss_l = 1'($urandom); miss_r = 1'($urandom);
          start = 1'($urandom); pause = 1'($urandom);
        end
        cyc();
      end
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0; start = 1'b0; pause = 1'b0;
    end
  endtask

  task automatic press_start(input string tag);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    ms = SERVE; ml = 0; mr = 0; mdir = 1; mwin = 0;
    check_all(tag);
  endtask

  task automatic serve(input string tag);
    ticks(SF - 1, 1'b1);
    chk({tag, ".hold"}, 32'(state), 32'(SERVE));
    ticks(1, 1'b1);
    ms = PLAY;
    check_all(tag);
  endtask

  // kind: 0 = missL, 1 = missR, 2 = both
  task automatic play_point(input string tag, input int kind);
    int wait_c;
    wait_c = $urandom_range(0, 5);
    for (int i = 0; i < wait_c; i++) begin
      frame_tick = 1'($urandom);
      cyc();
    end
    frame_tick = 1'b0;
    miss_l = (kind != 1);
    miss_r = (kind != 0);
    cyc();
    miss_l = 1'b0; miss_r = 1'b0;
    if (kind != 1) begin
      mr = (mr < WS) ? mr + 1 : mr;
      mdir = 0;
    end else begin
      ml = (ml < WS) ? ml + 1 : ml;
      mdir = 1;
    end
    ms = POINT;
    check_all({tag, ".miss"});
    ticks(PF - 1, 1'b1);
    chk({tag, ".freeze"}, 32'(state), 32'(POINT));
    ticks(1, 1'b1);
    if (ml == WS) begin
      ms = GAMEOVER; mwin = 1;
    end else if (mr == WS) begin
      ms = GAMEOVER; mwin = 2;
    end else begin
      ms = SERVE;
    end
    check_all({tag, ".after"});
  endtask

  task automatic pause_edge();
    pause = 1'b0;
    cyc();
    pause = 1'b1;
    cyc();
  endtask

  initial begin
    model_reset();
    // asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check_all("idle");

    for (int i = 0; i < 6; i++) begin
      frame_tick = 1'($urandom); miss_l = 1'($urandom); miss_r = 1'($urandom); pause = 1'($urandom);
      cyc();
    end
    frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0; pause = 1'b0;
    cyc();
    check_all("idle_noise");

    // game 1: right player wins
    press_start("start1");
    serve("serve1");
    play_point("pt_missR", 1);
    serve("serve2");
    play_point("pt_both", 2);
    for (int g = 0; g < 20 && mwin == 0; g++) begin
      serve("serve_r");
      play_point("pt_r", ($urandom_range(0, 1) == 0) ? 0 : 2);
    end
    chk("game1.winner", 32'(winner), 32'd2);
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; miss_l = 1'($urandom); miss_r = 1'($urandom);
      cyc();
    end
    frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    check_all("gameover_hold");

    // game 2: pause behaviour, then random play to a winner
    press_start("start2");
    serve("serve_p");
    pause_edge();
`ifdef PONG_PAUSE_EN
    ms = PAUSED;
    check_all("paused");
    miss_l = 1'b1; frame_tick = 1'b1;
    cyc();
    miss_l = 1'b0; frame_tick = 1'b0;
    cyc();
    check_all("paused_miss");
    pause_edge();
    ms = PLAY;
    check_all("resumed");
`else
    check_all("pause_ignored");
    pause_edge();
    check_all("pause_ignored2");
`endif
    pause = 1'b0;
    play_point("pt_g2", $urandom_range(0, 2));
    for (int g = 0; g < 30 && mwin == 0; g++) begin
      serve("serve_g2");
      play_point("pt_g2", $urandom_range(0, 2));
    end
    chk("game2.over", 32'(state), 32'(GAMEOVER));

    // reset in the middle of PLAY with a non-zero score
    press_start("start3");
    serve("serve3");
    play_point("pt3", 1);
    serve("serve4");
    cyc();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset_play");
    cyc();
    rst_n = 1'b1;
    cyc();
    check_all("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
